// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and sizing for the integer register file and its pending-write scoreboard.
package regfile_scoreboard_pkg;

  localparam int XLEN_C  = 64;
  localparam int NREG_C  = 32;
  localparam int CNT_W_C = 2;

  typedef logic [4:0]         reg_idx_t;
  typedef logic [CNT_W_C-1:0] sb_cnt_t;

  // Writeback port bundle, so the writeback stage can later drive one struct.
  typedef struct packed {
    logic              en;
    reg_idx_t          wd;
    logic [XLEN_C-1:0] data;
  } rf_write_t;

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register: inc on issue, dec on retire, clr on flush.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A retire with nothing outstanding is an underflow; the count stays at zero.
  always_comb begin
    err = dec && !inc && (cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x64 integer register file with write-through read ports and a per-register
// pending-write scoreboard that flags read-after-write hazards to decode.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN  = XLEN_C,
  parameter int NREG  = NREG_C,
  parameter int CNT_W = CNT_W_C
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en,
  input  reg_idx_t        wd,
  input  logic [XLEN-1:0] wb_data,
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            hazard1,
  output logic            hazard2,
  input  logic            issue_valid,
  input  reg_idx_t        issue_rd,
  output logic            issue_ok,
  input  logic            flush,
  output logic            sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  rf_write_t        wbWr;
  logic [XLEN-1:0]  regs [NREG];
  logic [CNT_W-1:0] cnt  [NREG];
  logic [NREG-1:0]  underflow;
  logic             issueFire;
  logic             overflow;
  logic             wbHitIssue;
  logic             wbHit1;
  logic             wbHit2;

  // A retiring writer that is the only one outstanding makes its value visible via bypass.
  function automatic logic hazardCalc(input reg_idx_t rs, input logic [CNT_W-1:0] c,
                                      input logic wbHit);
    return (rs != '0) && (c != '0) && !((c == CNT_W'(1)) && wbHit);
  endfunction

  function automatic logic [XLEN-1:0] readMux(input reg_idx_t rs, input logic wbHit,
                                              input logic [XLEN-1:0] wbVal,
                                              input logic [XLEN-1:0] stored);
    if (rs == '0)  return '0;
    else if (wbHit) return wbVal;
    else            return stored;
  endfunction

  assign wbWr = '{en: wb_en, wd: wd, data: wb_data};

  assign wbHit1     = wbWr.en && (wbWr.wd == rs1);
  assign wbHit2     = wbWr.en && (wbWr.wd == rs2);
  assign wbHitIssue = wbWr.en && (wbWr.wd == issue_rd);

  always_comb begin
    issue_ok  = (issue_rd == '0) || (cnt[issue_rd] != CNT_MAX) || wbHitIssue;
    issueFire = issue_valid && issue_ok;
    overflow  = issue_valid && !issue_ok;
  end

  always_comb begin
    rdata1  = readMux(rs1, wbHit1, wbWr.data, regs[rs1]);
    rdata2  = readMux(rs2, wbHit2, wbWr.data, regs[rs2]);
    hazard1 = hazardCalc(rs1, cnt[rs1], wbHit1);
    hazard2 = hazardCalc(rs2, cnt[rs2], wbHit2);
  end

  // Register storage; x0 is never written so it always reads back zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wbWr.en && (wbWr.wd != '0)) begin
      regs[wbWr.wd] <= wbWr.data;
    end
  end

  assign cnt[0]       = '0;
  assign underflow[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : gCnt
    sb_counter #(.CNT_W(CNT_W)) uCnt (
      .clk (clk),
      .rst (rst),
      .inc (issueFire && (issue_rd == reg_idx_t'(r))),
      .dec (wbWr.en && (wbWr.wd == reg_idx_t'(r))),
      .clr (flush),
      .cnt (cnt[r]),
      .err (underflow[r])
    );
  end

  // Sticky error: only reset clears it, flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_err <= 1'b0;
    end else if ((|underflow) || overflow) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed vector bench for regfile_scoreboard: table of per-cycle stimulus and expected outputs.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_en = 1'b0;
  logic [4:0]  wd = '0;
  logic [63:0] wb_data = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [63:0] rdata1;
  logic [63:0] rdata2;
  logic        hazard1;
  logic        hazard2;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_ok;
  logic        flush = 1'b0;
  logic        sb_err;

  int checks = 0;
  int failures = 0;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wd(wd), .wb_data(wb_data),
    .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2),
    .hazard1(hazard1), .hazard2(hazard2), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_ok(issue_ok), .flush(flush), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstPulse;
    logic        wbEn;
    logic [4:0]  wd;
    logic [63:0] wbData;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iv;
    logic [4:0]  ird;
    logic        fl;
    logic [63:0] expRd1;
    logic [63:0] expRd2;
    logic        expH1;
    logic        expH2;
    logic        expOk;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rp, logic we, logic [4:0] w, logic [63:0] d,
                              logic [4:0] a1, logic [4:0] a2, logic iv, logic [4:0] ird,
                              logic fl, logic [63:0] e1, logic [63:0] e2, logic h1,
                              logic h2, logic ok, logic er);
    vec_t v;
    v.rstPulse = rp; v.wbEn = we; v.wd = w; v.wbData = d; v.rs1 = a1; v.rs2 = a2;
    v.iv = iv; v.ird = ird; v.fl = fl; v.expRd1 = e1; v.expRd2 = e2;
    v.expH1 = h1; v.expH2 = h2; v.expOk = ok; v.expErr = er;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // rp we wd data   rs1 rs2 iv ird fl | rd1 rd2 h1 h2 ok err
    vecs.push_back(mk(0,0, 0,64'h0,        5, 0,0, 0,0, 64'h0,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        7, 0,1, 7,0, 64'h0,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        7, 0,0, 0,0, 64'h0,64'h0,1,0,1,0));
    vecs.push_back(mk(0,1, 7,64'hDEADBEEF, 7, 0,0, 0,0, 64'hDEADBEEF,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        7, 7,0, 7,0, 64'hDEADBEEF,64'hDEADBEEF,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        3, 0,1, 3,0, 64'h0,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        3, 0,1, 3,0, 64'h0,64'h0,1,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        3, 0,1, 3,0, 64'h0,64'h0,1,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        3, 0,1, 3,0, 64'h0,64'h0,1,0,0,0));
    vecs.push_back(mk(0,0, 0,64'h0,        3, 0,0, 3,0, 64'h0,64'h0,1,0,0,1));
    vecs.push_back(mk(0,1, 3,64'h33,       3, 0,1, 3,0, 64'h33,64'h0,1,0,1,1));
    vecs.push_back(mk(0,0, 0,64'h0,        3, 0,0, 3,0, 64'h33,64'h0,1,0,0,1));
    vecs.push_back(mk(0,0, 0,64'h0,        3, 0,0, 3,1, 64'h33,64'h0,1,0,0,1));
    vecs.push_back(mk(0,0, 0,64'h0,        3, 0,0, 3,0, 64'h33,64'h0,0,0,1,1));
    vecs.push_back(mk(1,0, 0,64'h0,        3, 7,0, 3,0, 64'h0,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        9, 0,1, 9,0, 64'h0,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        9, 0,1, 9,0, 64'h0,64'h0,1,0,1,0));
    vecs.push_back(mk(0,1, 9,64'h11,       9, 9,0, 0,0, 64'h11,64'h11,1,1,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        9, 0,0, 0,0, 64'h11,64'h0,1,0,1,0));
    vecs.push_back(mk(0,1, 9,64'h22,       9, 0,0, 0,0, 64'h22,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        9, 0,0, 0,0, 64'h22,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        4, 0,1, 4,0, 64'h0,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        4, 6,1, 6,0, 64'h0,64'h0,1,0,1,0));
    vecs.push_back(mk(0,1, 4,64'h55,       4, 6,1, 6,1, 64'h55,64'h0,0,1,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        4, 6,0, 6,0, 64'h55,64'h0,0,0,1,0));
    vecs.push_back(mk(0,1, 0,64'hFFFF,     0, 0,0, 0,0, 64'h0,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,        0, 0,0, 0,0, 64'h0,64'h0,0,0,1,0));
    vecs.push_back(mk(0,1,12,64'hABC,     12, 0,0, 0,0, 64'hABC,64'h0,0,0,1,0));
    vecs.push_back(mk(0,0, 0,64'h0,       12, 0,0, 0,0, 64'hABC,64'h0,0,0,1,1));
    vecs.push_back(mk(1,0, 0,64'h0,       12, 4,0, 0,0, 64'h0,64'h0,0,0,1,0));

    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      wb_en = vecs[i].wbEn; wd = vecs[i].wd; wb_data = vecs[i].wbData;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      issue_valid = vecs[i].iv; issue_rd = vecs[i].ird; flush = vecs[i].fl;
      if (vecs[i].rstPulse) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      #1;
      chk("rdata1",   i, rdata1,  vecs[i].expRd1);
      chk("rdata2",   i, rdata2,  vecs[i].expRd2);
      chk("hazard1",  i, 64'(hazard1),  64'(vecs[i].expH1));
      chk("hazard2",  i, 64'(hazard2),  64'(vecs[i].expH2));
      chk("issue_ok", i, 64'(issue_ok), 64'(vecs[i].expOk));
      chk("sb_err",   i, 64'(sb_err),   64'(vecs[i].expErr));
    end

    // Repeated issues to x0 must never count, never stall and never raise an error.
    @(negedge clk);
    wb_en = 1'b0; flush = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("x0_issue_ok", 100 + k, 64'(issue_ok), 64'd1);
      @(negedge clk);
    end
    issue_valid = 1'b0;
    #1;
    chk("x0_hazard", 200, 64'(hazard1), 64'd0);
    chk("x0_sb_err", 201, 64'(sb_err),  64'd0);

    // Asynchronous reset between edges clears register contents with no clock.
    @(negedge clk);
    wb_en = 1'b1; wd = 5'd20; wb_data = 64'h1234;
    @(negedge clk);
    wb_en = 1'b0; rs1 = 5'd20;
    #1;
    chk("pre_rst_rd", 300, rdata1, 64'h1234);
    rst = 1'b1;
    #1;
    chk("async_rst_rd", 301, rdata1, 64'h0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
